// File: rtl/pipe_skid_stage_pkg.sv
// pipe_skid_stage_pkg: shared skid-stage state naming for debug and assertions
package pipe_skid_stage_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } skid_state_t;
  function automatic skid_state_t skid_state(input logic skid_v, input logic main_v);
    return skid_state_t'({skid_v, main_v});
  endfunction
endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid-buffered pipeline register with registered ready
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [WIDTH-1:0] main_q, skid_q;
  logic main_v, skid_v, acc, snd;
  assign in_ready  = !skid_v;
  assign out_valid = main_v & !stall;
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready;
  assign snd       = out_valid & out_ready;
  // main holds the head payload; skid absorbs one arrival while the head is blocked
  always_ff @(posedge clk)
    if (rst || flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else if (skid_v) begin
      if (snd) begin
        main_q <= skid_q;
        skid_v <= 1'b0;
      end
    end else if (main_v) begin
      if (acc && snd) main_q <= in_data;
      else if (acc) begin
        skid_q <= in_data;
        skid_v <= 1'b1;
      end else if (snd) main_v <= 1'b0;
    end else if (acc) begin
      main_q <= in_data;
      main_v <= 1'b1;
    end
  // skid occupied without a head payload would break ordering
  always_ff @(posedge clk)
    assert (skid_state(skid_v, main_v) != skid_state_t'(2'b10));
endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Two-entry skid-buffered pipeline stage register with a fully registered valid/ready handshake in both directions. It sits between two core pipeline stages, for example ID→EX or EX→MEM, wherever the downstream ready must not propagate combinationally to the upstream stage. The payload is a flat vector: the stage wrapper packs and unpacks the stage-interface fields. The block supports an external stall, which holds the output, and a synchronous flush.

## Interface
- WIDTH, default 32: payload width in bits; the stage wrapper sets it to the packed stage-info width.
- RST_VAL, default 0: value loaded into both data registers on reset and on flush (DATA_INVALID).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous pipeline flush (branch mispredict or exception); discards both entries.
- stall  in  1  external stall; blocks the output transfer only.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept a payload; driven directly from a flop.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  main entry holds a payload and stall is low.
- out_ready  in  1  downstream accepts the payload.
- out_data  out  WIDTH  main entry payload; driven directly from a flop.

## Operation
- Storage:
  - main entry: main_q, main_v.
  - skid entry: skid_q, skid_v.
- States, encoded by {skid_v, main_v}:
  - EMPTY = 00.
  - ONE = 01.
  - TWO = 11.
  - 10 is illegal and must never occur.
- Handshake signals:
  - in_ready = !skid_v.
  - out_valid = main_v & !stall.
  - acc = in_valid & in_ready.
  - snd = out_valid & out_ready.
- Transitions; priority is rst > flush > normal:
  - EMPTY: acc → ONE, main_q ← in_data.
  - ONE, acc & snd → ONE, main_q ← in_data.
  - ONE, acc & !snd → TWO, skid_q ← in_data.
  - ONE, !acc & snd → EMPTY.
  - ONE, neither → hold.
  - TWO: in_ready = 0, so acc = 0. snd → ONE, main_q ← skid_q, skid_v ← 0. !snd → hold.
- Flush:
  - main_v and skid_v ← 0; main_q and skid_q ← RST_VAL.
  - A payload accepted in the flush cycle is dropped.
  - A send in the flush cycle still counts downstream.
- Stall:
  - Forces out_valid = 0 combinationally.
  - Upstream may keep filling until TWO; contents are held.
- Ordering: payloads leave in exact acceptance order. No duplication, no loss except on flush.

## Timing
- Reset values: main_v = 0, skid_v = 0, out_valid = 0, out_data = RST_VAL. in_ready = 1 from the first cycle after rst deasserts, and also while rst is held.
- Latency: a payload accepted in cycle N appears on out_data/out_valid in cycle N+1 (EMPTY or ONE with a send).
- Throughput: one payload per cycle sustained while out_ready = 1 and stall = 0.
- Backpressure: when out_ready drops while in ONE with in_valid = 1, the stage absorbs exactly one more payload (→ TWO). in_ready falls one cycle after out_ready falls. This is the registered-ready guarantee.
- Combinational paths: none from out_ready to in_ready, none from in_valid/in_data to out_valid/out_data. The only combinational input-to-output path is stall to out_valid.
- Simultaneous events:
  - flush with acc, or with acc & snd: the result is EMPTY.
  - rst mid-TWO: both entries are discarded and the next state is EMPTY.
- Recovery: in_ready is 1 in the cycle after a flush that hit TWO.

## Structure
- The shared pipeline package holds:
  - typedef enum skid_state_t {EMPTY, ONE, TWO}, used for debug/assertions only; state is derived from the valid bits.
  - The `DATA_INVALID/`ADDR_INVALID constants, which remain in constant.sv.
- No sub-module. Per-stage wrappers (e.g. id_ex_skid) instantiate it and pack/unpack id_stage_if.
- Embedded assertion: !(skid_v & !main_v).

## Test plan
- Reset: hold rst 3 cycles with in_valid = 1, in_data = 0xAAAA_AAAA → out_valid = 0, out_data = 0, in_ready = 1; the first cycle after reset accepts 0xAAAA_AAAA, which appears on out_data the following cycle.
- Streaming: send 0x1, 0x2, 0x3, 0x4 back-to-back with out_ready = 1 → out_data shows 1, 2, 3, 4 on consecutive cycles, one cycle delayed; in_ready stays 1.
- Backpressure: stream 0x10, 0x11, 0x12 and drop out_ready after 0x10 is visible → 0x11 is captured in skid, in_ready = 0 next cycle, and 0x12 is held upstream; raise out_ready → output order 0x10, 0x11, 0x12 with no loss.
- Stall: in ONE with main = 0x55, assert stall for 4 cycles with out_ready = 1 → out_valid = 0 throughout, 0x55 is still presented after stall drops, and no duplicate is sent.
- Flush in TWO with in_valid = 1 → next cycle out_valid = 0, out_data = RST_VAL, in_ready = 1, and the payload offered in the flush cycle never emerges.
- Random: drive in_valid, out_ready, stall and sparse flush randomly for 10k cycles → the scoreboard matches in-order delivery between flushes, and state 10 is never reached.
